// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: FIFO of predicted branches resolved in order; emits predictor updates and mispredict flushes.
// Ports: clk, rst (async, active-high); push/push_tag/push_pred enqueue a prediction;
// res_valid/res_taken resolve the oldest entry; upd_we/upd_tag/upd_t/mispredict are registered
// one cycle after resolution; full/empty/count report occupancy; err is a sticky protocol flag.
// Optional macro BRQ_STATS_EN adds saturating stat_resolved/stat_mispred counters.
module branch_resolve_queue #(
  parameter int TAG_LEN = 10,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [TAG_LEN-1:0] push_tag,
  input  logic push_pred,
  input  logic res_valid,
  input  logic res_taken,
  output logic upd_we,
  output logic [TAG_LEN-1:0] upd_tag,
  output logic upd_t,
  output logic mispredict,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count,
  output logic err
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_mispred
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [TAG_LEN-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [AW-1:0] head, tail;
  logic push_ok, res_ok, mis, wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign res_ok = res_valid && !empty;
  assign mis = res_ok && (res_taken != pred_mem[head]);
  // a flush wins over a same-cycle push: the younger branch is on the wrong path
  assign wr = push_ok && !mis;
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_mem[tail] <= push_tag;
      pred_mem[tail] <= push_pred;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      upd_we <= 1'b0;
      upd_tag <= '0;
      upd_t <= 1'b0;
      mispredict <= 1'b0;
      err <= 1'b0;
    end else begin
      upd_we <= res_ok;
      mispredict <= mis;
      if (res_ok) begin
        upd_tag <= tag_mem[head];
        upd_t <= res_taken;
      end
      if ((push && full) || (res_valid && empty)) err <= 1'b1;
      if (mis) begin
        head <= tail;
        count <= '0;
      end else begin
        if (res_ok) head <= head + AW'(1);
        if (push_ok) tail <= tail + AW'(1);
        count <= count + (AW+1)'(push_ok) - (AW+1)'(res_ok);
      end
    end
  end
`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd_we && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (mispredict && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed plus randomized check of branch_resolve_queue against a queue model.
module tb_branch_resolve_queue;
  localparam int TL = 10;
  localparam int D = 4;
  logic clk = 0, rst = 1, push = 0, push_pred = 0, res_valid = 0, res_taken = 0;
  logic [TL-1:0] push_tag = '0;
  logic upd_we, upd_t, mispredict, full, empty, err;
  logic [TL-1:0] upd_tag;
  logic [$clog2(D):0] count;
`ifdef BRQ_STATS_EN
  logic [15:0] stat_resolved, stat_mispred;
`endif
  branch_resolve_queue #(.TAG_LEN(TL), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .push_tag(push_tag), .push_pred(push_pred),
    .res_valid(res_valid), .res_taken(res_taken), .upd_we(upd_we), .upd_tag(upd_tag),
    .upd_t(upd_t), .mispredict(mispredict), .full(full), .empty(empty), .count(count), .err(err)
`ifdef BRQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model: a queue of {tag,pred}, plus the last update seen
  logic [TL:0] q[$];
  logic [TL:0] mh;
  bit m_err, m_we, m_mis, m_t, mf, me;
  logic [TL-1:0] m_tag;
  int m_sr, m_sm;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_err = 0; m_we = 0; m_mis = 0; m_t = 0; m_tag = '0; m_sr = 0; m_sm = 0;
    end else begin
      if (m_we && m_sr < 65535) m_sr++;
      if (m_mis && m_sm < 65535) m_sm++;
      mf = q.size() == D;
      me = q.size() == 0;
      m_we = 0;
      m_mis = 0;
      if ((push && mf) || (res_valid && me)) m_err = 1;
      if (res_valid && !me) begin
        mh = q.pop_front();
        m_we = 1;
        m_tag = mh[TL:1];
        m_t = res_taken;
        if (res_taken != mh[0]) begin
          m_mis = 1;
          q.delete();
        end
      end
      if (push && !mf && !m_mis) q.push_back({push_tag, push_pred});
    end
  end
  always @(negedge clk) begin
    chk("count", count, q.size());
    chk("full", full, q.size() == D);
    chk("empty", empty, q.size() == 0);
    chk("err", err, m_err);
    chk("upd_we", upd_we, m_we);
    chk("mispredict", mispredict, m_mis);
    chk("upd_tag", upd_tag, m_tag);
    chk("upd_t", upd_t, m_t);
`ifdef BRQ_STATS_EN
    chk("stat_resolved", stat_resolved, m_sr);
    chk("stat_mispred", stat_mispred, m_sm);
`endif
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_push(input int t, input bit p);
    push = 1; push_tag = TL'(t); push_pred = p;
    step();
    push = 0;
  endtask
  task automatic do_res(input bit t);
    res_valid = 1; res_taken = t;
    step();
    res_valid = 0;
  endtask
  initial begin
    step(2);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_upd_we", upd_we, 0);
    chk("rst_err", err, 0);
    chk("rst_upd_tag", upd_tag, 0);
    rst = 0;
    for (int k = 1; k <= 4; k++) do_push(k, 1);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    do_push(5, 1);
    chk("overflow_err", err, 1);
    chk("overflow_count", count, 4);
    do_res(1);
    chk("res1_we", upd_we, 1);
    chk("res1_tag", upd_tag, 1);
    chk("res1_t", upd_t, 1);
    chk("res1_mis", mispredict, 0);
    chk("res1_count", count, 3);
    step();
    chk("hold_we", upd_we, 0);
    chk("hold_tag", upd_tag, 1);
    do_res(0);
    chk("mis_flag", mispredict, 1);
    chk("mis_t", upd_t, 0);
    chk("mis_tag", upd_tag, 2);
    chk("mis_count", count, 0);
    chk("mis_empty", empty, 1);
    do_push('h10, 0);
    do_push('h11, 0);
    push = 1; push_tag = TL'('h12); push_pred = 0; res_valid = 1; res_taken = 0;
    step();
    push = 0; res_valid = 0;
    chk("pushpop_count", count, 2);
    chk("pushpop_tag", upd_tag, 'h10);
    chk("pushpop_mis", mispredict, 0);
    do_res(0);
    chk("drain_tag0", upd_tag, 'h11);
    do_res(0);
    chk("drain_tag1", upd_tag, 'h12);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) do_push('h20 + r * 4 + k, 1);
      for (int k = 0; k < 4; k++) begin
        do_res(1);
        chk("wrap_tag", upd_tag, 'h20 + r * 4 + k);
      end
    end
    do_push('h30, 1);
    do_push('h31, 1);
    res_valid = 1; res_taken = 1; rst = 1;
    step(2);
    chk("midrst_count", count, 0);
    chk("midrst_err", err, 0);
    chk("midrst_we", upd_we, 0);
    rst = 0;
    step();
    res_valid = 0;
    chk("empty_res_err", err, 1);
    chk("empty_res_we", upd_we, 0);
`ifdef BRQ_STATS_EN
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      do_push('h40 + k, 1);
      do_res(1);
    end
    for (int k = 0; k < 2; k++) begin
      do_push('h50 + k, 1);
      do_res(0);
    end
    step();
    chk("stat_res5", stat_resolved, 5);
    chk("stat_mis2", stat_mispred, 2);
`endif
    for (int i = 0; i < 3000; i++) begin
      push = $urandom_range(0, 99) < 60;
      push_tag = TL'($urandom);
      push_pred = $urandom_range(0, 1) == 1;
      res_valid = $urandom_range(0, 99) < 45;
      res_taken = q.size() != 0 ? (($urandom_range(0, 99) < 85) ? q[0][0] : ~q[0][0]) : $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 399) == 0;
      step();
    end
    push = 0; res_valid = 0; rst = 0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
